// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the single-ported data memory.
// Define DMEM_ARB_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_memread,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_read_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd0_q, rd1_q;

  logic          load;
  logic          sel;
  logic          pick;
  logic          other_req;

`ifdef DMEM_ARB_PRIO_EN
  // Port 0 always wins; port 1 only when port 0 is quiet.
  assign pick      = ~m0_req;
  assign other_req = gnt_q ? m0_req : (m1_req & ~m0_req);
`else
  // Tie goes to the rr pointer; a sole requester always wins.
  assign pick      = (m0_req & m1_req) ? rr_q : ~m0_req;
  assign other_req = gnt_q ? m0_req : m1_req;
`endif

  // Next-state, grant selection and request latching.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load    = 1'b0;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          load    = 1'b1;
          sel     = pick;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (other_req) begin
          load    = 1'b1;
          sel     = ~gnt_q;
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      gnt_d   = sel;
      we_d    = sel ? m1_we    : m0_we;
      addr_d  = sel ? m1_addr  : m0_addr;
      wdata_d = sel ? m1_wdata : m0_wdata;
`ifdef DMEM_ARB_PRIO_EN
      rr_d    = 1'b0;
`else
      rr_d    = ~sel;
`endif
    end
  end

  // State, pointer and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Capture read data into the grantee's return register at end of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else if (state_q == ACCESS && !we_q) begin
      if (gnt_q) rd1_q <= mem_read_data;
      else       rd0_q <= mem_read_data;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_memread    = (state_q == ACCESS) & ~we_q;
  assign mem_memwrite   = (state_q == ACCESS) &  we_q;
  assign m0_ack         = (state_q == DONE) & ~gnt_q;
  assign m1_ack         = (state_q == DONE) &  gnt_q;
  assign m0_rdata       = rd0_q;
  assign m1_rdata       = rd1_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
// Memory model: 256x32 array, combinational read, preloaded mem[i]=i on reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ack;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ack;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memread, mem_memwrite;
  logic        busy;

  logic [31:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;
  int m_chk  = 0;
  int m_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_ack         (m0_ack),
    .m0_rdata       (m0_rdata),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_ack         (m1_ack),
    .m1_rdata       (m1_rdata),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  assign mem_read_data = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= i;
    end else if (mem_memwrite) begin
      mem[mem_addr[7:0]] <= mem_write_data;
    end
  end

  always @(negedge clk) begin
    m_chk++;
    assert (!(mem_memread && mem_memwrite)) else begin
      m_fail++;
      $error("FAIL rd_wr_excl observed=%b%b expected=not both",
             mem_memread, mem_memwrite);
    end
    m_chk++;
    assert (!(m0_ack && m1_ack)) else begin
      m_fail++;
      $error("FAIL ack_excl observed=%b%b expected=not both", m0_ack, m1_ack);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ack0"}, {31'd0, m0_ack}, 32'd0);
    chk({tag, "_ack1"}, {31'd0, m1_ack}, 32'd0);
    chk({tag, "_rd"}, {31'd0, mem_memread}, 32'd0);
    chk({tag, "_wr"}, {31'd0, mem_memwrite}, 32'd0);
  endtask

  initial begin
    logic e0, e1;
    rst      = 1'b1;
    m0_req   = 1'b1;
    m0_we    = 1'b0;
    m0_addr  = 32'h04;
    m0_wdata = 32'h0;
    m1_req   = 1'b1;
    m1_we    = 1'b0;
    m1_addr  = 32'h02;
    m1_wdata = 32'h0;

    // 1: reset with both requesting
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle("rst");
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
      chk("rst_rdata0", m0_rdata, 32'h0);
      chk("rst_rdata1", m1_rdata, 32'h0);
    end
    rst = 1'b0;
    step();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_grant0_addr", mem_addr, 32'h04);
    chk("t1_rd", {31'd0, mem_memread}, 32'd1);
    step();
    chk("t1_ack0", {31'd0, m0_ack}, 32'd1);
    chk("t1_rdata0", m0_rdata, 32'h04);
    m0_req = 1'b0;
    step();
    chk("t1_grant1_addr", mem_addr, 32'h02);
    chk("t1_rd1", {31'd0, mem_memread}, 32'd1);
    step();
    chk("t1_ack1", {31'd0, m1_ack}, 32'd1);
    chk("t1_rdata1", m1_rdata, 32'h02);
    m1_req = 1'b0;
    step();
    chk_idle("t1_end");

    // 2: m0 read 0x04
    m0_req  = 1'b1;
    m0_we   = 1'b0;
    m0_addr = 32'h04;
    chk("t2_no_early_ack", {31'd0, m0_ack}, 32'd0);
    step();
    chk("t2_rd", {31'd0, mem_memread}, 32'd1);
    chk("t2_wr", {31'd0, mem_memwrite}, 32'd0);
    chk("t2_addr", mem_addr, 32'h04);
    chk("t2_ack_early", {31'd0, m0_ack}, 32'd0);
    step();
    chk("t2_ack0", {31'd0, m0_ack}, 32'd1);
    chk("t2_ack1", {31'd0, m1_ack}, 32'd0);
    chk("t2_rd_off", {31'd0, mem_memread}, 32'd0);
    chk("t2_rdata", m0_rdata, 32'h04);
    m0_req = 1'b0;
    step();
    chk_idle("t2_end");
    chk("t2_addr_hold", mem_addr, 32'h04);

    // 3: m1 write 0x08 then read it back
    m1_req   = 1'b1;
    m1_we    = 1'b1;
    m1_addr  = 32'h08;
    m1_wdata = 32'hFFFF_FFF7;
    step();
    chk("t3_wr", {31'd0, mem_memwrite}, 32'd1);
    chk("t3_rd", {31'd0, mem_memread}, 32'd0);
    chk("t3_addr", mem_addr, 32'h08);
    chk("t3_wdata", mem_write_data, 32'hFFFF_FFF7);
    step();
    chk("t3_wack", {31'd0, m1_ack}, 32'd1);
    chk("t3_wr_off", {31'd0, mem_memwrite}, 32'd0);
    chk("t3_wrdata_hold", m1_rdata, 32'h02);
    m1_req = 1'b0;
    step();
    chk_idle("t3_mid");
    m1_req = 1'b1;
    m1_we  = 1'b0;
    step();
    chk("t3_rd2", {31'd0, mem_memread}, 32'd1);
    step();
    chk("t3_rack", {31'd0, m1_ack}, 32'd1);
    chk("t3_rdata", m1_rdata, 32'hFFFF_FFF7);
    m1_req = 1'b0;
    step();
    chk_idle("t3_end");

    // 4: both ports requesting continuously
    m0_req  = 1'b1;
    m0_we   = 1'b0;
    m0_addr = 32'h01;
    m1_req  = 1'b1;
    m1_we   = 1'b0;
    m1_addr = 32'h02;
    for (int c = 1; c <= 8; c++) begin
      step();
`ifdef DMEM_ARB_PRIO_EN
      e0 = (c % 3 == 2);
      e1 = 1'b0;
`else
      e0 = (c % 4 == 2);
      e1 = (c % 4 == 0);
`endif
      chk($sformatf("t4_ack0_c%0d", c), {31'd0, m0_ack}, {31'd0, e0});
      chk($sformatf("t4_ack1_c%0d", c), {31'd0, m1_ack}, {31'd0, e1});
      if (e0) chk($sformatf("t4_rdata0_c%0d", c), m0_rdata, 32'h01);
      if (e1) chk($sformatf("t4_rdata1_c%0d", c), m1_rdata, 32'h02);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    chk_idle("t4_end");

    // 5: reset during ACCESS of an m1 write
    m1_req   = 1'b1;
    m1_we    = 1'b1;
    m1_addr  = 32'h10;
    m1_wdata = 32'hDEAD_BEEF;
    step();
    chk("t5_wr", {31'd0, mem_memwrite}, 32'd1);
    chk("t5_addr", mem_addr, 32'h10);
    rst    = 1'b1;
    m1_req = 1'b0;
    step();
    chk_idle("t5_rst");
    chk("t5_addr0", mem_addr, 32'h0);
    chk("t5_wdata0", mem_write_data, 32'h0);
    chk("t5_rdata0", m0_rdata, 32'h0);
    chk("t5_rdata1", m1_rdata, 32'h0);
    rst = 1'b0;
    step();
    chk_idle("t5_after");
    step();
    chk_idle("t5_after2");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk + m_chk, n_fail + m_fail);
    $finish;
  end

endmodule
